// File: rtl/pe_pkg.sv
// Shared types and constants for the PE row drain logic.
package pe_pkg;

    localparam int unsigned PE_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } pe_drain_state_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_row_drain_if.sv
// Valid/ready result stream from the row drain controller to the output writer.
interface pe_row_drain_if #(
    parameter int unsigned DATA_W = pe_pkg::PE_DATA_W,
    parameter int unsigned COL_W  = 2
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [COL_W-1:0]  col;

    modport master (
        output valid,
        output data,
        output col,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  col,
        output ready
    );

endinterface

// File: rtl/pe_drain_buf.sv
// Row result buffer: one write port, one write-through read port, async clear.
// Build with PE_DRAIN_RELU_EN defined to clamp negative captures to zero.
module pe_drain_buf
    import pe_pkg::*;
#(
    parameter int unsigned N_COLS = 4,
    parameter int unsigned DATA_W = PE_DATA_W,
    parameter int unsigned COL_W  = idx_w(N_COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [COL_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [N_COLS];
    logic [DATA_W-1:0] wr_val;

    always_comb begin
`ifdef PE_DRAIN_RELU_EN
        wr_val = wr_data[DATA_W-1] ? '0 : wr_data;
`else
        wr_val = wr_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COLS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_COLS; i++) begin
                if (wr_en && (wr_idx == COL_W'(i))) begin
                    mem_q[i] <= wr_val;
                end
            end
        end
    end

    // Forward a same-cycle write so the last column can be read as it lands.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (rd_idx == COL_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_data = wr_val;
        end
    end

endmodule

// File: rtl/pe_row_drain.sv
// Drains one systolic row through the PE read chain, buffers it and streams it out.
// Optional build macro PE_DRAIN_RELU_EN clamps negative results to zero at capture.
module pe_row_drain
    import pe_pkg::*;
#(
    parameter int unsigned N_COLS = 4,
    parameter int unsigned DATA_W = PE_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  pe_read,
    input  logic [DATA_W-1:0]     pe_l_d_i,
    output logic                  busy,
    output logic                  done,
    pe_row_drain_if.master        out
);

    localparam int unsigned COL_W = idx_w(N_COLS);
    localparam int unsigned CNT_W = COL_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N_COLS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    pe_drain_state_t   state_q, state_d;
    logic [CNT_W-1:0]  c_q, c_d;
    logic [COL_W-1:0]  idx_q, idx_d;
    logic              pe_read_q, pe_read_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              wr_en;
    logic [COL_W-1:0]  wr_idx;
    logic [COL_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              hs;

    // Odd cycles of the drain window carry column c/2.
    assign wr_en  = (state_q == DRAIN) && c_q[0];
    assign wr_idx = c_q[CNT_W-1:1];
    // Prefetch the word that becomes current after this edge.
    assign rd_idx = (state_q == FLUSH) ? idx_q + COL_W'(1) : '0;
    assign hs     = valid_q && out.ready;

    pe_drain_buf #(
        .N_COLS (N_COLS),
        .DATA_W (DATA_W),
        .COL_W  (COL_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (pe_l_d_i),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        idx_d     = idx_q;
        pe_read_d = pe_read_q;
        valid_d   = valid_q;
        data_d    = data_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                c_d = '0;
                if (start) begin
                    state_d   = DRAIN;
                    pe_read_d = 1'b1;
                end
            end
            DRAIN: begin
                c_d = c_q + CNT_W'(1);
                if (c_q == CNT_LAST) begin
                    state_d   = FLUSH;
                    pe_read_d = 1'b0;
                    idx_d     = '0;
                    valid_d   = 1'b1;
                    data_d    = rd_data;
                end
            end
            FLUSH: begin
                if (hs) begin
                    if (idx_q == COL_LAST) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + COL_W'(1);
                        data_d = rd_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            idx_q     <= '0;
            pe_read_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            idx_q     <= idx_d;
            pe_read_q <= pe_read_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign pe_read   = pe_read_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out.valid = valid_q;
    assign out.data  = data_q;
    assign out.col   = idx_q;

endmodule
